uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_tx_core.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmitter: one-entry holding register feeding a shift register, serialised on baud-enable pulses.
// Supports 5..9 data bits, optional odd/even parity, 1 or 2 stop bits, LSB/MSB-first order and line break.
module uart_tx_core #(
    parameter int         DATA_WIDTH  = 8,
    parameter logic [1:0] PARITY_MODE = 2'b00,
    parameter int         STOP_BITS   = 1,
    parameter bit         MSB_FIRST   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_clk,
    input  logic [DATA_WIDTH-1:0] tx_i_data,
    input  logic                  tx_i_start,
    input  logic                  tx_i_break,
    output logic                  tx_o_ready,
    output logic                  tx_o_busy,
    output logic                  tx_o_done,
    output logic                  tx_o_data
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    // state | meaning: IDLE line high | START start bit | DATA data bits
    //       | PARITY parity bit | STOP stop bits | BREAK line held low
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  line_q, line_d;
    logic                  done_q, done_d;

    logic                  load;
    logic                  take;
    logic                  out_bit;
    logic [DATA_WIDTH-1:0] shifted;

    assign load    = tx_i_start & ~hold_full_q;
    assign out_bit = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
    assign shifted = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[DATA_WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        line_d      = line_q;
        done_d      = 1'b0;
        take        = 1'b0;

        if (tx_clk) begin
            case (state_q)
                S_IDLE: begin
                    if (tx_i_break) begin
                        line_d  = 1'b0;
                        state_d = S_BREAK;
                    end else if (hold_full_q) begin
                        take    = 1'b1;
                        line_d  = 1'b0;
                        state_d = S_START;
                    end else begin
                        line_d = 1'b1;
                    end
                end
                S_START: begin
                    line_d    = out_bit;
                    shift_d   = shifted;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (int'(bit_cnt_q) < DATA_WIDTH - 1) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        line_d    = out_bit;
                        shift_d   = shifted;
                    end else if (PARITY_MODE[0]) begin
                        line_d  = par_q;
                        state_d = S_PARITY;
                    end else begin
                        line_d     = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
                S_PARITY: begin
                    line_d     = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    if (int'(stop_cnt_q) < STOP_BITS - 1) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                        line_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // Pending data chains straight into the next start bit.
                        if (hold_full_q && !tx_i_break) begin
                            take    = 1'b1;
                            line_d  = 1'b0;
                            state_d = S_START;
                        end else begin
                            line_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    if (tx_i_break) begin
                        line_d = 1'b0;
                    end else begin
                        line_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    line_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end

        // Parity latched with the frame so later shifting cannot disturb it.
        if (take) begin
            shift_d = hold_q;
            par_d   = PARITY_MODE[1] ? ^hold_q : ~^hold_q;
        end

        hold_full_d = (hold_full_q & ~take) | load;
        if (load) begin
            hold_d = tx_i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            line_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            line_q      <= line_d;
            done_q      <= done_d;
        end
    end

    assign tx_o_ready = ~hold_full_q;
    assign tx_o_busy  = (state_q != S_IDLE);
    assign tx_o_done  = done_q;
    assign tx_o_data  = line_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: default, 7-bit even/odd parity with two stops, and MSB-first instances.
module tb_uart_tx_core;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       tx_clk  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       start_m = 1'b0;
    logic       start_p = 1'b0;
    logic       start_r = 1'b0;
    logic       brk     = 1'b0;
    logic       zero    = 1'b0;

    logic rdy_m, busy_m, done_m, line_m;
    logic rdy_e, busy_e, done_e, line_e;
    logic rdy_o, busy_o, done_o, line_o;
    logic rdy_r, busy_r, done_r, line_r;

    int checks = 0;
    int errors = 0;
    int baud_div = 4;
    int div_cnt = 0;
    int n_done_m = 0, n_done_e = 0, n_done_o = 0, n_done_r = 0;

    uart_tx_core u_main (
        .clk(clk), .reset(reset), .tx_clk(tx_clk), .tx_i_data(tx_data),
        .tx_i_start(start_m), .tx_i_break(brk),
        .tx_o_ready(rdy_m), .tx_o_busy(busy_m), .tx_o_done(done_m), .tx_o_data(line_m)
    );

    uart_tx_core #(.DATA_WIDTH(7), .PARITY_MODE(2'b11), .STOP_BITS(2)) u_even (
        .clk(clk), .reset(reset), .tx_clk(tx_clk), .tx_i_data(tx_data[6:0]),
        .tx_i_start(start_p), .tx_i_break(zero),
        .tx_o_ready(rdy_e), .tx_o_busy(busy_e), .tx_o_done(done_e), .tx_o_data(line_e)
    );

    uart_tx_core #(.DATA_WIDTH(7), .PARITY_MODE(2'b01), .STOP_BITS(2)) u_odd (
        .clk(clk), .reset(reset), .tx_clk(tx_clk), .tx_i_data(tx_data[6:0]),
        .tx_i_start(start_p), .tx_i_break(zero),
        .tx_o_ready(rdy_o), .tx_o_busy(busy_o), .tx_o_done(done_o), .tx_o_data(line_o)
    );

    uart_tx_core #(.PARITY_MODE(2'b10), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .tx_clk(tx_clk), .tx_i_data(tx_data),
        .tx_i_start(start_r), .tx_i_break(zero),
        .tx_o_ready(rdy_r), .tx_o_busy(busy_r), .tx_o_done(done_r), .tx_o_data(line_r)
    );

    always #5 clk = ~clk;

    // Baud enable changes on the falling edge so the DUT sees a stable level.
    always @(negedge clk) begin
        if (div_cnt >= baud_div - 1) begin
            tx_clk  = 1'b1;
            div_cnt = 0;
        end else begin
            tx_clk  = 1'b0;
            div_cnt = div_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (done_m === 1'b1) n_done_m++;
        if (done_e === 1'b1) n_done_e++;
        if (done_o === 1'b1) n_done_o++;
        if (done_r === 1'b1) n_done_r++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] frame8(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Returns on the falling edge after the next clk edge that carries tx_clk.
    task automatic wait_bit();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            if (tx_clk) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_bit: tx_clk pulse actual=none required=one within 64 clk");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (line_m !== 1'b1) begin errors++; $display("FAIL reset_line: actual=%b required=1", line_m); end
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL reset_ready: actual=%b required=1", rdy_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: actual=%b required=0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset_done: actual=%b required=0", done_m); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_bit();
            checks++;
            if (line_m !== 1'b1 || busy_m !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet%0d: line=%b busy=%b required line=1 busy=0", i, line_m, busy_m);
            end
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        int d0;
        baud_div = 16;
        d0 = n_done_m;
        exp = frame8(8'h55);
        tx_data = 8'h55; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL basic_ready_after_load: actual=%b required=0", rdy_m); end
        for (int i = 0; i < 10; i++) begin
            wait_bit();
            checks++;
            if (line_m !== exp[i]) begin errors++; $display("FAIL basic_bit%0d: actual=%b required=%b", i, line_m, exp[i]); end
        end
        wait_bit();
        @(negedge clk);
        checks++; if (line_m !== 1'b1) begin errors++; $display("FAIL basic_idle_line: actual=%b required=1", line_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL basic_busy_end: actual=%b required=0", busy_m); end
        checks++; if (n_done_m - d0 !== 1) begin errors++; $display("FAIL basic_done_count: actual=%0d required=1", n_done_m - d0); end
    endtask

    task automatic test_parity();
        logic [10:0] exp_e, exp_o;
        int de, dd;
        baud_div = 4;
        de = n_done_e; dd = n_done_o;
        exp_e = {2'b11, 1'b1, 7'h07, 1'b0};
        exp_o = {2'b11, 1'b0, 7'h07, 1'b0};
        tx_data = 8'h07; start_p = 1'b1;
        @(negedge clk); start_p = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wait_bit();
            checks++;
            if (line_e !== exp_e[i]) begin errors++; $display("FAIL even_bit%0d: actual=%b required=%b", i, line_e, exp_e[i]); end
            checks++;
            if (line_o !== exp_o[i]) begin errors++; $display("FAIL odd_bit%0d: actual=%b required=%b", i, line_o, exp_o[i]); end
        end
        checks++; if (busy_e !== 1'b1) begin errors++; $display("FAIL even_busy_second_stop: actual=%b required=1", busy_e); end
        wait_bit();
        @(negedge clk);
        checks++; if (n_done_e - de !== 1) begin errors++; $display("FAIL even_done_count: actual=%0d required=1", n_done_e - de); end
        checks++; if (n_done_o - dd !== 1) begin errors++; $display("FAIL odd_done_count: actual=%0d required=1", n_done_o - dd); end
        checks++; if (busy_e !== 1'b0) begin errors++; $display("FAIL even_busy_end: actual=%b required=0", busy_e); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        int d0;
        baud_div = 8;
        d0 = n_done_m;
        exp = {frame8(8'h3C), frame8(8'hA5)};
        tx_data = 8'hA5; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: actual=%b required=0", rdy_m); end
        wait_bit();
        checks++; if (line_m !== exp[0]) begin errors++; $display("FAIL b2b_bit0: actual=%b required=%b", line_m, exp[0]); end
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_start: actual=%b required=1", rdy_m); end
        tx_data = 8'h3C; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL b2b_ready_second: actual=%b required=0", rdy_m); end
        tx_data = 8'hFF; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        for (int i = 1; i < 20; i++) begin
            wait_bit();
            checks++;
            if (line_m !== exp[i]) begin errors++; $display("FAIL b2b_bit%0d: actual=%b required=%b", i, line_m, exp[i]); end
        end
        for (int i = 0; i < 12; i++) begin
            wait_bit();
            checks++;
            if (line_m !== 1'b1) begin errors++; $display("FAIL b2b_third_ignored%0d: actual=%b required=1", i, line_m); end
        end
        @(negedge clk);
        checks++; if (n_done_m - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: actual=%0d required=2", n_done_m - d0); end
        checks++; if (busy_m !== 1'b0 || rdy_m !== 1'b1) begin errors++; $display("FAIL b2b_end_state: busy=%b ready=%b required busy=0 ready=1", busy_m, rdy_m); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        baud_div = 4;
        tx_data = 8'hFF; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        repeat (5) wait_bit();
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: actual=%b required=1", busy_m); end
        tx_data = 8'h81; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        checks++; if (rdy_m !== 1'b0) begin errors++; $display("FAIL midrst_pending: actual=%b required=0", rdy_m); end
        #2 reset = 1'b1;
        #1;
        checks++; if (line_m !== 1'b1) begin errors++; $display("FAIL midrst_line: actual=%b required=1", line_m); end
        checks++; if (rdy_m !== 1'b1) begin errors++; $display("FAIL midrst_ready: actual=%b required=1", rdy_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL midrst_busy: actual=%b required=0", busy_m); end
        @(negedge clk);
        reset = 1'b0;
        exp = frame8(8'h0F);
        tx_data = 8'h0F; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_bit();
            checks++;
            if (line_m !== exp[i]) begin errors++; $display("FAIL midrst_frame_bit%0d: actual=%b required=%b", i, line_m, exp[i]); end
        end
        for (int i = 0; i < 12; i++) begin
            wait_bit();
            checks++;
            if (line_m !== 1'b1) begin errors++; $display("FAIL midrst_no_stale%0d: actual=%b required=1", i, line_m); end
        end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL midrst_busy_end: actual=%b required=0", busy_m); end
    endtask

    task automatic test_break();
        logic [9:0] exp;
        int d0;
        baud_div = 4;
        wait_bit();
        d0 = n_done_m;
        exp = frame8(8'h5A);
        brk = 1'b1; tx_data = 8'h5A; start_m = 1'b1;
        @(negedge clk); start_m = 1'b0;
        for (int i = 0; i < 30; i++) begin
            wait_bit();
            checks++;
            if (line_m !== 1'b0) begin errors++; $display("FAIL break_low%0d: actual=%b required=0", i, line_m); end
        end
        checks++; if (rdy_m !== 1'b0 || busy_m !== 1'b1) begin errors++; $display("FAIL break_state: ready=%b busy=%b required ready=0 busy=1", rdy_m, busy_m); end
        brk = 1'b0;
        wait_bit();
        checks++; if (line_m !== 1'b1) begin errors++; $display("FAIL break_release: actual=%b required=1", line_m); end
        for (int i = 0; i < 10; i++) begin
            wait_bit();
            checks++;
            if (line_m !== exp[i]) begin errors++; $display("FAIL break_frame_bit%0d: actual=%b required=%b", i, line_m, exp[i]); end
        end
        wait_bit();
        @(negedge clk);
        checks++; if (n_done_m - d0 !== 1) begin errors++; $display("FAIL break_done_count: actual=%0d required=1", n_done_m - d0); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL break_busy_end: actual=%b required=0", busy_m); end
    endtask

    task automatic test_fast_msb();
        logic [9:0] exp;
        logic [7:0] d;
        int d0;
        baud_div = 1;
        d = 8'hB1;
        exp[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp[1 + k] = d[7 - k];
        exp[9] = 1'b1;
        d0 = n_done_r;
        tx_data = d; start_r = 1'b1;
        @(negedge clk); start_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_bit();
            checks++;
            if (line_r !== exp[i]) begin errors++; $display("FAIL msb_fast_bit%0d: actual=%b required=%b", i, line_r, exp[i]); end
        end
        wait_bit();
        @(negedge clk);
        checks++; if (n_done_r - d0 !== 1) begin errors++; $display("FAIL msb_done_count: actual=%0d required=1", n_done_r - d0); end
        checks++; if (busy_r !== 1'b0 || line_r !== 1'b1) begin errors++; $display("FAIL msb_end_state: busy=%b line=%b required busy=0 line=1", busy_r, line_r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_break();
        test_fast_msb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
